// File: rtl/switch_pio_debounced.sv
// Avalon-MM input PIO for switches/buttons: 2-flop sync, per-bit debounce,
// edge capture with W1C, interrupt mask and a level IRQ.
module switch_pio_debounced #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] set_edge;
  logic [WIDTH-1:0] clr_edge;
  logic             wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
      logic [CW-1:0] cnt_q, cnt_d;
      logic          differs;

      assign differs  = (s2_q[gi] != db_q[gi]);
      assign flip[gi] = differs && (cnt_q == CNT_MAX);

      always_comb begin
        cnt_d = '0;
        if (differs && (cnt_q != CNT_MAX))
          cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          cnt_q <= '0;
        else
          cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign db_d = db_q ^ flip;

  // The bit takes s2's value when it flips, so s2 tells the edge direction.
  generate
    if (EDGE_MODE == 1) begin : g_fall
      assign set_edge = flip & ~s2_q;
    end else if (EDGE_MODE == 2) begin : g_any
      assign set_edge = flip;
    end else begin : g_rise
      assign set_edge = flip & s2_q;
    end
  endgenerate

  generate
    if (WIDTH < 32) begin : g_wd_unused
      logic unused_writedata;
      assign unused_writedata = ^writedata[31:WIDTH];
    end
  endgenerate

  assign wr_en    = chipselect && !write_n;
  assign clr_edge = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd2)
      irqmask_d = writedata[WIDTH-1:0];
    // A new edge in the same cycle as its W1C keeps the bit set.
    edgecap_d = (edgecap_q & ~clr_edge) | set_edge;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(db_q);
      2'd2:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q       <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      db_q       <= db_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_switch_pio_debounced.sv
// Directed bench for switch_pio_debounced (WIDTH=8, DEBOUNCE_CYCLES=4); a second
// instance with any-edge capture shares the stimulus.
module tb_switch_pio_debounced;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata, readdata_any;
  logic        irq, irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_pio_debounced #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  switch_pio_debounced #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_any), .irq(irq_any)
  );

  typedef struct {
    logic        do_wr;
    logic [1:0]  wr_addr;
    logic [31:0] wdata;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end else begin
      $display("ok   %s: %08h", name, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_000B, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 2'd2, 32'hFFFF_FF00, 2'd2, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 32'h0000_00A5, 2'd2, 32'h0000_00A5, 1'b0};
    vecs[5] = '{1'b1, 2'd2, 32'hFFFF_FF5A, 2'd2, 32'h0000_005A, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_000B, 1'b0};
    vecs[7] = '{1'b1, 2'd3, 32'h0000_00FF, 2'd3, 32'h0000_0000, 1'b0};
    vecs[8] = '{1'b1, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000, 1'b0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;

    // 1. reset state and first debounce of inputs held high
    tick(3);
    check("reset readdata", readdata, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick(5);
    bus_read(2'd0);
    check("post-reset data before 6th edge", readdata, 32'h0);
    bus_read(2'd0);
    check("post-reset data after 6 edges", readdata, 32'h0000_00FF);
    bus_read(2'd3);
    check("post-reset edgecapture", readdata, 32'h0000_00FF);
    check("post-reset irq masked", 32'(irq), 32'h0);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3);
    check("w1c clears all", readdata, 32'h0);
    in_port = 8'h00;
    tick(8);
    check("falling edges not captured", readdata, 32'h0);
    check("any-edge captures falls", readdata_any, 32'h0000_00FF);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3);
    check("any-edge cleared", readdata_any, 32'h0);

    // 2. glitch rejection, then shortest accepted pulse
    in_port = 8'h01;
    tick(3);
    in_port = 8'h00;
    tick(8);
    bus_read(2'd0);
    check("3-cycle glitch data", readdata, 32'h0);
    bus_read(2'd3);
    check("3-cycle glitch edge", readdata, 32'h0);
    address = 2'd0;
    in_port = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 4) in_port = 8'h00;
      if (k == 6) check("4-cycle pulse db before edge 6", readdata, 32'h0);
      if (k == 7) check("4-cycle pulse db at edge 6", readdata, 32'h0000_0001);
    end
    tick(8);
    bus_read(2'd3);
    check("4-cycle pulse edge", readdata, 32'h0000_0001);
    check("4-cycle pulse edge any", readdata_any, 32'h0000_0001);
    bus_read(2'd0);
    check("pulse released data", readdata, 32'h0);

    // 3. IRQ path: edgecapture is set on the 6th edge and irq follows combinationally
    bus_write(2'd2, 32'h01);
    bus_write(2'd3, 32'hFF);
    check("irq idle", 32'(irq), 32'h0);
    in_port = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 5) check("irq before debounce done", 32'(irq), 32'h0);
      if (k == 6) check("irq asserted", 32'(irq), 32'h1);
      if (k == 7) check("irq held", 32'(irq), 32'h1);
    end
    bus_write(2'd3, 32'h01);
    check("irq drops after w1c", 32'(irq), 32'h0);
    in_port = 8'h03;
    tick(8);
    check("irq ignores masked bit1", 32'(irq), 32'h0);
    bus_write(2'd2, 32'h02);
    check("irq from bit1 when unmasked", 32'(irq), 32'h1);
    bus_write(2'd2, 32'h00);
    check("irq drops after mask write", 32'(irq), 32'h0);
    bus_read(2'd3);
    check("edgecapture bit1 still set", readdata, 32'h0000_0002);

    // 4. falling edge on bit 2
    bus_write(2'd3, 32'hFF);
    in_port = 8'h07;
    tick(8);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h03;
    tick(8);
    bus_read(2'd0);
    check("bit2 fell data", readdata, 32'h0000_0003);
    bus_read(2'd3);
    check("rising mode ignores fall", readdata, 32'h0);
    check("any mode captures fall", readdata_any, 32'h0000_0004);

    // 5. W1C lands on the same edge db[3] rises: set wins
    in_port = 8'h0B;
    tick(5);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3);
    check("set beats clear", readdata, 32'h0000_0008);
    check("set beats clear any", readdata_any, 32'h0000_000C);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3);
    check("later clear works", readdata, 32'h0);
    bus_write(2'd3, 32'hFF);

    // 6. register map, read latency and ignored writes
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wdata);
      bus_read(vecs[i].rd_addr);
      check($sformatf("vec%0d read a%0d", i, vecs[i].rd_addr), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // reset mid-count discards progress; the count restarts from zero
    address = 2'd0;
    in_port = 8'h1B;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("async reset readdata", readdata, 32'h0);
    check("async reset irq", 32'(irq_any), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    bus_read(2'd0);
    check("restart data before 6th edge", readdata, 32'h0);
    bus_read(2'd0);
    check("restart data after 6 edges", readdata, 32'h0000_001B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
